// File: rtl/regfile_alu_sequencer.sv
// Command-queued sequencer for the 32x32 regfile + ALU datapath: FIFO -> RD -> WB -> RSP.
// Optional build macro REGFILE_SEQ_X0_GUARD_EN suppresses write-back to register 0.
module regfile_alu_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_zero,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 3 * ADDR_W + OP_W;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WB,
        S_RSP
    } state_e;

    state_e state_q, state_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic [ADDR_W-1:0] cur_rd_q, cur_rd_d;
    logic [ADDR_W-1:0] cur_rs1_q, cur_rs1_d;
    logic [ADDR_W-1:0] cur_rs2_q, cur_rs2_d;
    logic [OP_W-1:0]   cur_op_q, cur_op_d;
    logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;

    logic full, empty, push, pop, wr_allow;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

`ifdef REGFILE_SEQ_X0_GUARD_EN
    assign wr_allow = (wr_reg_q != '0);
`else
    assign wr_allow = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush aborts from any state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (!empty) state_d = S_RD;
                S_RD:    state_d = S_WB;
                S_WB:    state_d = S_RSP;
                S_RSP:   if (resp_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and handshake decode
    always_comb begin
        cmd_ready  = !full;
        push       = cmd_valid && !full && !flush;
        pop        = (state_q == S_IDLE) && !empty && !flush;
        rf_write   = (state_q == S_WB) && wr_allow;
        resp_valid = (state_q == S_RSP);
        busy       = (state_q != S_IDLE) || !empty;
    end

    assign rf_read_reg1  = cur_rs1_q;
    assign rf_read_reg2  = cur_rs2_q;
    assign alu_op        = cur_op_q;
    assign rf_write_reg  = wr_reg_q;
    assign rf_write_data = result_q;
    assign resp_data     = result_q;
    assign resp_zero     = zero_q;

    // FIFO and current-op datapath
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        cur_rd_d  = cur_rd_q;
        cur_rs1_d = cur_rs1_q;
        cur_rs2_d = cur_rs2_q;
        cur_op_d  = cur_op_q;
        wr_reg_d  = wr_reg_q;
        result_d  = result_q;
        zero_d    = zero_q;

        if (push) begin
            mem_d[wr_ptr_q] = {cmd_rd, cmd_rs1, cmd_rs2, cmd_op};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            {cur_rd_d, cur_rs1_d, cur_rs2_d, cur_op_d} = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Write address moves with the captured result so both change together entering WB
        if (state_q == S_RD) begin
            result_d = alu_result;
            zero_d   = alu_zero;
            wr_reg_d = cur_rd_q;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cur_rd_q  <= '0;
            cur_rs1_q <= '0;
            cur_rs2_q <= '0;
            cur_op_q  <= '0;
            wr_reg_q  <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cur_rd_q  <= cur_rd_d;
            cur_rs1_q <= cur_rs1_d;
            cur_rs2_q <= cur_rs2_d;
            cur_op_q  <= cur_op_d;
            wr_reg_q  <= wr_reg_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Bench for regfile_alu_sequencer: behavioural regfile/ALU environment plus an
// in-order array model of register contents; honours REGFILE_SEQ_X0_GUARD_EN.
module tb_regfile_alu_sequencer;

    localparam int DEPTH = 4;
    localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2,
                           OP_SUB = 4'd6, OP_SLT = 4'd7, OP_NOR = 4'd12;
`ifdef REGFILE_SEQ_X0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] op;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst, flush, cmd_valid, cmd_ready, resp_ready;
    logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [3:0]  cmd_op;
    logic [4:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [31:0] rf_write_data, alu_result, resp_data;
    logic        rf_write, alu_zero, resp_valid, resp_zero, busy;
    logic [3:0]  alu_op;

    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] rf [32];
    logic [31:0] mdl_rf [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_alu_sequencer #(.ADDR_W(5), .DATA_W(32), .OP_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_op(cmd_op),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data), .rf_write(rf_write),
        .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_zero(resp_zero), .busy(busy)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_NOR:  return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Environment: regfile written by the DUT strobe, ALU combinational from read ports
    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (rf_write) rf[rf_write_reg] <= rf_write_data;
    end
    assign alu_result = alu_fn(rf[rf_read_reg1], rf[rf_read_reg2], alu_op);
    assign alu_zero   = (alu_result == 32'd0);

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
        mdl_rf[a] = d;
    endtask

    task automatic drive_cmd(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_rd = c.rd; cmd_rs1 = c.rs1; cmd_rs2 = c.rs2; cmd_op = c.op;
    endtask

    function automatic cmd_t rand_cmd(input int lo, input int hi);
        cmd_t c;
        logic [3:0] ops [6];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
        c.rd  = 5'($urandom_range(hi, lo));
        c.rs1 = 5'($urandom_range(hi, 0));
        c.rs2 = 5'($urandom_range(hi, 0));
        c.op  = ops[$urandom_range(5, 0)];
        return c;
    endfunction

    // One op from an idle, empty sequencer with exact-latency checks
    task automatic run_op(input cmd_t c);
        logic [31:0] exp;
        logic        exp_we;
        exp    = alu_fn(mdl_rf[c.rs1], mdl_rf[c.rs2], c.op);
        exp_we = !(GUARD && c.rd == 5'd0);
        drive_cmd(c);
        check("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rd_reg1", 32'(rf_read_reg1), 32'(c.rs1));
        check("rd_reg2", 32'(rf_read_reg2), 32'(c.rs2));
        check("rd_aluop", 32'(alu_op), 32'(c.op));
        check("rd_nowrite", 32'(rf_write), 32'd0);
        tick();
        check("wb_we", 32'(rf_write), 32'(exp_we));
        if (exp_we) begin
            check("wb_reg", 32'(rf_write_reg), 32'(c.rd));
            check("wb_data", rf_write_data, exp);
            mdl_rf[c.rd] = exp;
        end
        check("wb_norsp", 32'(resp_valid), 32'd0);
        tick();
        check("rsp_valid", 32'(resp_valid), 32'd1);
        check("rsp_data", resp_data, exp);
        check("rsp_zero", 32'(resp_zero), 32'(exp == 32'd0));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("rsp_done", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        cmd_t        c;
        cmd_t        q[$];
        logic [31:0] exp;
        int          n;

        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; resp_ready = 1'b0;
        cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_op = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_rf_write", 32'(rf_write), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_wr_data", rf_write_data, 32'd0);
        check("rst_read_reg1", 32'(rf_read_reg1), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 32; i++) preload(5'(i), (i == 0) ? 32'd0 : $urandom);
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);

        // Basic ADD r3 = r1 + r2
        c = '{rd: 5'd3, rs1: 5'd1, rs2: 5'd2, op: OP_ADD};
        run_op(c);
        check("add_r3_contents", rf[3], 32'd12);

        // Reset asserted mid-RD
        drive_cmd('{rd: 5'd9, rs1: 5'd1, rs2: 5'd2, op: OP_ADD});
        tick();
        cmd_valid = 1'b0;
        tick();
        check("midrd_reg1", 32'(rf_read_reg1), 32'd1);
        rst = 1'b1;
        #1;
        check("midrd_rst_resp", 32'(resp_valid), 32'd0);
        check("midrd_rst_ready", 32'(cmd_ready), 32'd1);
        check("midrd_rst_busy", 32'(busy), 32'd0);
        check("midrd_rst_reg1", 32'(rf_read_reg1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrd_nowrite", 32'(rf_write), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("midrd_r9_kept", rf[9], mdl_rf[9]);
        check("midrd_idle", 32'(busy), 32'd0);

        // SUB to zero with stalled response; second command must wait
        drive_cmd('{rd: 5'd4, rs1: 5'd1, rs2: 5'd1, op: OP_SUB});
        tick();
        drive_cmd('{rd: 5'd5, rs1: 5'd2, rs2: 5'd1, op: OP_ADD});
        tick();
        cmd_valid = 1'b0;
        tick();
        mdl_rf[4] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_data", resp_data, 32'd0);
            check("stall_zero", 32'(resp_zero), 32'd1);
            check("stall_reg1", 32'(rf_read_reg1), 32'd1);
            check("stall_nowrite", 32'(rf_write), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("stall_released", 32'(resp_valid), 32'd0);
        exp = mdl_rf[2] + mdl_rf[1];
        tick();
        check("next_reg1", 32'(rf_read_reg1), 32'd2);
        tick();
        check("next_we", 32'(rf_write), 32'd1);
        check("next_wreg", 32'(rf_write_reg), 32'd5);
        check("next_wdata", rf_write_data, exp);
        mdl_rf[5] = exp;
        tick();
        check("next_rsp", resp_data, 32'd12);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("r4_zero", rf[4], 32'd0);

        // Fill to full with a stalled response, then drain in order
        for (int i = 0; i < DEPTH + 1; i++) begin
            c = rand_cmd(8, 15);
            drive_cmd(c);
            n = 0;
            while (!cmd_ready && n < 20) begin tick(); n++; end
            check("fill_ready", 32'(cmd_ready), 32'd1);
            q.push_back(c);
            tick();
        end
        check("full_ready_low", 32'(cmd_ready), 32'd0);
        drive_cmd(rand_cmd(8, 15));
        tick(); tick();
        cmd_valid = 1'b0;
        check("full_still_low", 32'(cmd_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        resp_ready = 1'b1;
        while (q.size() > 0) begin
            c   = q.pop_front();
            exp = alu_fn(mdl_rf[c.rs1], mdl_rf[c.rs2], c.op);
            mdl_rf[c.rd] = exp;
            n = 0;
            while (!resp_valid && n < 12) begin tick(); n++; end
            check("drain_valid", 32'(resp_valid), 32'd1);
            check("drain_data", resp_data, exp);
            check("drain_zero", 32'(resp_zero), 32'(exp == 32'd0));
            tick();
        end
        resp_ready = 1'b0;
        tick();
        check("drain_idle", 32'(busy), 32'd0);
        for (int r = 8; r < 16; r++) check("drain_rf", rf[r], mdl_rf[r]);

        // Flush during WB with two commands queued; flush also beats a push
        drive_cmd('{rd: 5'd20, rs1: 5'd1, rs2: 5'd2, op: OP_OR});
        tick();
        drive_cmd('{rd: 5'd21, rs1: 5'd1, rs2: 5'd2, op: OP_ADD});
        tick();
        drive_cmd('{rd: 5'd22, rs1: 5'd1, rs2: 5'd2, op: OP_ADD});
        tick();
        drive_cmd('{rd: 5'd23, rs1: 5'd1, rs2: 5'd2, op: OP_ADD});
        flush = 1'b1;
        exp = mdl_rf[1] | mdl_rf[2];
        check("flush_wb_we", 32'(rf_write), 32'd1);
        check("flush_wb_reg", 32'(rf_write_reg), 32'd20);
        check("flush_wb_data", rf_write_data, exp);
        mdl_rf[20] = exp;
        tick();
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(cmd_ready), 32'd1);
        check("flush_norsp", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("flush_quiet", 32'({rf_write, resp_valid, busy}), 32'd0);
        end
        for (int r = 20; r < 24; r++) check("flush_rf", rf[r], mdl_rf[r]);

        // Destination register 0
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        run_op('{rd: 5'd0, rs1: 5'd1, rs2: 5'd2, op: OP_ADD});
        check("x0_contents", rf[0], GUARD ? 32'd0 : 32'd12);

        // Random single ops against the model
        for (int i = 0; i < 30; i++) run_op(rand_cmd(0, 31));
        for (int r = 0; r < 32; r++) check("final_rf", rf[r], mdl_rf[r]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
